spike_rate_decoder: RTL and testbench

- Receiver end of the neuron spike interface: consumes the 1-cycle spike pulses a LIF/LSNN neuron emits and decodes them into per-window rate and inter-spike-interval (ISI) records.
- Records are buffered in a small FIFO and drained by a downstream consumer over a valid/ready handshake.
- Sits between the neuron core's spike output and the readout/telemetry logic.

---
 rtl/spike_rate_decoder.sv | 125 ++++++++++++
 tb/tb_spike_rate_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike rate / min-ISI decoder with record FIFO; burst flag built only with SPIKE_DECODER_BURST_EN
module spike_rate_decoder #(
  parameter int WINDOW_CYCLES = 256,
  parameter int COUNT_WIDTH   = 8,
  parameter int ISI_WIDTH     = 12,
  parameter int FIFO_DEPTH    = 4,
  parameter int BURST_ISI     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           spike_in,
  output logic                           rec_valid,
  input  logic                           rec_ready,
  output logic [COUNT_WIDTH-1:0]         rec_count,
  output logic [ISI_WIDTH-1:0]           rec_isi_min,
  output logic                           rec_isi_vld,
  output logic                           rec_burst,
  output logic                           drop_sticky,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
  localparam int WW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int LW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [LW:0] FULL = (LW+1)'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ISI_WIDTH-1:0] ISI_MAX = '1;

  if (WINDOW_CYCLES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BURST_ISI < 0) begin : g_bad_cfg
    $error("spike_rate_decoder: illegal parameter set");
  end

  logic [0:0]             state;
  logic [WW-1:0]          win;
  logic [COUNT_WIDTH-1:0] cnt, cnt_n;
  logic [ISI_WIDTH-1:0]   isi_min, min_n, gap;
  logic                   isi_vld, vld_n, have_prev;
  logic                   run, sp, hit, close, pop, full, wr;
  logic [LW-1:0]          wp, rp;
  logic [LW:0]            level;
  logic [COUNT_WIDTH-1:0] mem_cnt [FIFO_DEPTH];
  logic [ISI_WIDTH-1:0]   mem_min [FIFO_DEPTH];
  logic                   mem_vld [FIFO_DEPTH];

  always_comb begin
    run   = state == S_RUN && en;
    sp    = run && spike_in;
    hit   = sp && have_prev;
    cnt_n = (sp && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
    min_n = (hit && gap < isi_min) ? gap : isi_min;
    vld_n = isi_vld | hit;
    close = run && win == WIN_LAST;
    pop   = rec_valid && rec_ready;
    full  = level == FULL;
    wr    = close && (!full || pop);
  end

  // Leaving RUN (or sitting in IDLE) discards the partial window and the ISI history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      win       <= '0;
      cnt       <= '0;
      isi_min   <= ISI_MAX;
      isi_vld   <= 1'b0;
      have_prev <= 1'b0;
      gap       <= '0;
    end else begin
      state     <= en ? S_RUN : S_IDLE;
      win       <= (!run || close) ? '0 : win + 1'b1;
      cnt       <= (!run || close) ? '0 : cnt_n;
      isi_min   <= (!run || close) ? ISI_MAX : min_n;
      isi_vld   <= (!run || close) ? 1'b0 : vld_n;
      have_prev <= run && (have_prev || sp);
      gap       <= !run ? '0 : sp ? ISI_WIDTH'(1) : (gap == ISI_MAX) ? gap : gap + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      drop_sticky <= 1'b0;
    end else begin
      wp          <= wr ? wp + 1'b1 : wp;
      rp          <= pop ? rp + 1'b1 : rp;
      level       <= level + (LW+1)'(wr) - (LW+1)'(pop);
      drop_sticky <= drop_sticky | (close && !wr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_cnt[wp] <= cnt_n;
      mem_min[wp] <= min_n;
      mem_vld[wp] <= vld_n;
    end
  end

  assign rec_valid   = level != '0;
  assign fifo_level  = level;
  assign rec_count   = rec_valid ? mem_cnt[rp] : '0;
  assign rec_isi_min = rec_valid ? mem_min[rp] : '0;
  assign rec_isi_vld = rec_valid ? mem_vld[rp] : 1'b0;

`ifdef SPIKE_DECODER_BURST_EN
  localparam logic [ISI_WIDTH-1:0] BURST = ISI_WIDTH'(BURST_ISI);
  logic burst, burst_n;
  logic mem_burst [FIFO_DEPTH];
  assign burst_n = burst | (hit && gap <= BURST);
  always_ff @(posedge clk) begin
    if (rst) burst <= 1'b0;
    else burst <= (run && !close) && burst_n;
  end
  always_ff @(posedge clk) begin
    if (wr) mem_burst[wp] <= burst_n;
  end
  assign rec_burst = rec_valid ? mem_burst[rp] : 1'b0;
`else
  assign rec_burst = 1'b0;
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed scoreboard bench for spike_rate_decoder (16-cycle windows, 3-bit count)
module tb_spike_rate_decoder;
  typedef struct {
    logic [2:0]  c;
    logic [11:0] m;
    logic        v;
    logic        b;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        spike_in = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid, rec_isi_vld, rec_burst, drop_sticky;
  logic [2:0]  rec_count;
  logic [11:0] rec_isi_min;
  logic [2:0]  fifo_level;
  rec_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          m_have = 0;
  int          m_gap = 0;

  spike_rate_decoder #(
    .WINDOW_CYCLES(16), .COUNT_WIDTH(3), .ISI_WIDTH(12), .FIFO_DEPTH(4), .BURST_ISI(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_count(rec_count),
    .rec_isi_min(rec_isi_min), .rec_isi_vld(rec_isi_vld), .rec_burst(rec_burst),
    .drop_sticky(drop_sticky), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full aligned window; the expected record is built from the drive pattern.
  task automatic window(input logic [15:0] pat, input bit keep, input bit chk);
    rec_t r;
    r.c = 3'd0; r.m = 12'hfff; r.v = 1'b0; r.b = 1'b0;
    for (int c = 0; c < 16; c++) begin
      spike_in = pat[c];
      if (pat[c]) begin
        if (r.c != 3'd7) r.c = r.c + 3'd1;
        if (m_have != 0) begin
          r.v = 1'b1;
          if (m_gap < int'(r.m)) r.m = 12'(m_gap);
`ifdef SPIKE_DECODER_BURST_EN
          if (m_gap <= 4) r.b = 1'b1;
`endif
        end
        m_have = 1;
        m_gap = 1;
      end else if (m_gap < 4095) m_gap++;
      tick();
      if (chk && c == 0) check("valid_pulse_end", 32'(rec_valid), 32'd0);
    end
    spike_in = 1'b0;
    if (keep) q.push_back(r);
    if (chk) check("valid_after_close", 32'(rec_valid), 32'd1);
  endtask

  task automatic restart();
    spike_in = 1'b0;
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    tick();
    m_have = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      check("rec_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        rec_t e;
        e = q.pop_front();
        check("rec_count", 32'(rec_count), 32'(e.c));
        check("rec_isi_min", 32'(rec_isi_min), 32'(e.m));
        check("rec_isi_vld", 32'(rec_isi_vld), 32'(e.v));
        check("rec_burst", 32'(rec_burst), 32'(e.b));
      end
    end
  end

  initial begin
    tick();
    tick();
    check("rst_valid", 32'(rec_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_sticky), 32'd0);
    check("rst_count", 32'(rec_count), 32'd0);
    check("rst_isi_min", 32'(rec_isi_min), 32'd0);
    check("rst_isi_vld", 32'(rec_isi_vld), 32'd0);
    check("rst_burst", 32'(rec_burst), 32'd0);
    rst = 1'b0;
    rec_ready = 1'b1;
    en = 1'b1;
    tick();
    m_have = 0;
    for (int w = 0; w < 3; w++) window(16'h1084, 1'b1, 1'b1);
    window(16'hffff, 1'b1, 1'b1);
    for (int c = 0; c < 9; c++) begin
      spike_in = (c == 1 || c == 4);
      tick();
    end
    spike_in = 1'b0;
    en = 1'b0;
    tick();
    tick();
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    check("partial_discarded", 32'(fifo_level), 32'd0);
    en = 1'b1;
    tick();
    m_have = 0;
    window(16'h0408, 1'b1, 1'b1);
    restart();
    window(16'h0001, 1'b1, 1'b1);
    window(16'h0001, 1'b1, 1'b1);
    restart();
    rec_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      window((16'h1 << k) - 16'h1, k <= 4, 1'b0);
      if (k == 4) begin
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_no_drop", 32'(drop_sticky), 32'd0);
      end
    end
    check("overflow_level", 32'(fifo_level), 32'd4);
    check("overflow_drop", 32'(drop_sticky), 32'd1);
    en = 1'b0;
    tick();
    rec_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("drained_level", 32'(fifo_level), 32'd0);
    check("drained_queue", 32'(q.size()), 32'd0);
    rec_ready = 1'b0;
    en = 1'b1;
    tick();
    m_have = 0;
    for (int w = 0; w < 3; w++) window(16'h0101, 1'b0, 1'b0);
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    rec_ready = 1'b1;
    en = 1'b0;
    tick();
    rst = 1'b0;
    check("post_rst_valid", 32'(rec_valid), 32'd0);
    check("post_rst_level", 32'(fifo_level), 32'd0);
    check("post_rst_drop", 32'(drop_sticky), 32'd0);
    check("post_rst_count", 32'(rec_count), 32'd0);
    en = 1'b1;
    tick();
    m_have = 0;
    window(16'h8001, 1'b1, 1'b1);
    en = 1'b0;
    tick();
    tick();
    check("final_level", 32'(fifo_level), 32'd0);
    check("final_queue", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
